// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, registers ROM data into ir_o, handles start/branch/stall/halt; FETCH_COUNT_EN adds fetch_cnt_o
module fetch_unit #(
  parameter logic [7:0] PROG0_START = 8'h00,
  parameter logic [7:0] PROG1_START = 8'h3D,
  parameter logic [7:0] PROG2_START = 8'h6D,
  parameter logic [7:0] HALT_OPCODE = 8'b00000010
) (
  input  logic        clck,
  input  logic        reset,
  input  logic        start_i,
  input  logic [1:0]  prog_sel_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [7:0]  branch_target_i,
  input  logic [7:0]  instr_i,
  output logic [7:0]  pc_o,
  output logic [7:0]  ir_o,
  output logic [7:0]  ir_pc_o,
  output logic        ir_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        wrap_o,
  output logic [15:0] fetch_cnt_o
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state;
  logic [7:0] start_pc;
  // program select 3 falls back to the first program
  always_comb start_pc = prog_sel_i == 2'd1 ? PROG1_START : prog_sel_i == 2'd2 ? PROG2_START : PROG0_START;
  assign busy_o = state == RUN;
  assign done_o = state == HALTED;
  // fetch FSM: stall beats branch beats normal fetch; a halt opcode is captured and freezes the PC
  always_ff @(posedge clck or posedge reset)
    if (reset) begin
      state      <= IDLE;
      pc_o       <= 8'h00;
      ir_o       <= 8'h00;
      ir_pc_o    <= 8'h00;
      ir_valid_o <= 1'b0;
      wrap_o     <= 1'b0;
    end else if (state != RUN) begin
      if (start_i) begin
        state      <= RUN;
        pc_o       <= start_pc;
        ir_valid_o <= 1'b0;
        wrap_o     <= 1'b0;
      end else if (state == HALTED)
        ir_valid_o <= ir_valid_o & stall_i;
    end else if (!stall_i) begin
      if (branch_i) begin
        pc_o       <= branch_target_i;
        ir_valid_o <= 1'b0;
      end else begin
        ir_o       <= instr_i;
        ir_pc_o    <= pc_o;
        ir_valid_o <= 1'b1;
        if (pc_o == 8'hFF) wrap_o <= 1'b1;
        if (instr_i == HALT_OPCODE) state <= HALTED;
        else pc_o <= pc_o + 8'd1;
      end
    end
`ifdef FETCH_COUNT_EN
  logic [15:0] cnt;
  logic fetch;
  assign fetch = state == RUN && !stall_i && !branch_i;
  assign fetch_cnt_o = cnt;
  // saturating count of normal-path fetches, cleared by a program launch
  always_ff @(posedge clck or posedge reset)
    if (reset) cnt <= 16'h0000;
    else if (state != RUN && start_i) cnt <= 16'h0000;
    else if (fetch && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
`else
  assign fetch_cnt_o = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic clck = 1'b0;
  logic reset = 1'b1;
  logic start_i = 1'b0;
  logic [1:0] prog_sel_i = 2'd0;
  logic stall_i = 1'b0;
  logic branch_i = 1'b0;
  logic [7:0] branch_target_i = 8'h00;
  logic [7:0] instr_i;
  logic [7:0] pc_o, ir_o, ir_pc_o;
  logic ir_valid_o, busy_o, done_o, wrap_o;
  logic [15:0] fetch_cnt_o;
  logic [7:0] rom [256];
  typedef struct packed {logic [7:0] pc; logic [7:0] ir;} exp_t;
  exp_t sb[$];
  logic [7:0] m_pc;
  int checks = 0;
  int failures = 0;
`ifdef FETCH_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  fetch_unit dut (
    .clck(clck), .reset(reset), .start_i(start_i), .prog_sel_i(prog_sel_i),
    .stall_i(stall_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
    .instr_i(instr_i), .pc_o(pc_o), .ir_o(ir_o), .ir_pc_o(ir_pc_o),
    .ir_valid_o(ir_valid_o), .busy_o(busy_o), .done_o(done_o), .wrap_o(wrap_o),
    .fetch_cnt_o(fetch_cnt_o)
  );

  always #5 clck = ~clck;
  assign instr_i = rom[pc_o];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clck);
    #1;
  endtask

  task automatic fetch(input int n);
    exp_t e;
    repeat (n) begin
      sb.push_back({m_pc, rom[m_pc]});
      m_pc = m_pc + 8'd1;
      tick();
      e = sb.pop_front();
      chk("ir", {24'd0, ir_o}, {24'd0, e.ir});
      chk("ir_pc", {24'd0, ir_pc_o}, {24'd0, e.pc});
      chk("ir_valid", {31'd0, ir_valid_o}, 32'd1);
      chk("pc", {24'd0, pc_o}, {24'd0, m_pc});
    end
  endtask

  task automatic launch(input logic [1:0] sel, input logic [7:0] exp_pc);
    start_i = 1'b1;
    prog_sel_i = sel;
    tick();
    start_i = 1'b0;
    m_pc = exp_pc;
    chk("start_pc", {24'd0, pc_o}, {24'd0, exp_pc});
    chk("start_valid", {31'd0, ir_valid_o}, 32'd0);
    chk("start_busy", {31'd0, busy_o}, 32'd1);
    chk("start_wrap", {31'd0, wrap_o}, 32'd0);
    chk("start_cnt", {16'd0, fetch_cnt_o}, 32'd0);
  endtask

  task automatic halt_step(input int exp_cnt);
    tick();
    chk("halt_ir", {24'd0, ir_o}, 32'h02);
    chk("halt_ir_pc", {24'd0, ir_pc_o}, {24'd0, m_pc});
    chk("halt_valid", {31'd0, ir_valid_o}, 32'd1);
    chk("halt_pc", {24'd0, pc_o}, {24'd0, m_pc});
    chk("halt_done", {31'd0, done_o}, 32'd1);
    chk("halt_busy", {31'd0, busy_o}, 32'd0);
    branch_i = 1'b1;
    branch_target_i = 8'h77;
    tick();
    branch_i = 1'b0;
    chk("halt_valid_clr", {31'd0, ir_valid_o}, 32'd0);
    chk("halt_pc_hold", {24'd0, pc_o}, {24'd0, m_pc});
    chk("halt_done_hold", {31'd0, done_o}, 32'd1);
    chk("halt_cnt", {16'd0, fetch_cnt_o}, CNT_ON ? exp_cnt : 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {i[6:0], 1'b1};
    rom[8'h00] = 8'b00001100;
    rom[8'h28] = 8'b11111110;
    rom[8'h3C] = 8'b00000010;
    #12;
    chk("rst_pc", {24'd0, pc_o}, 32'd0);
    chk("rst_ir", {24'd0, ir_o}, 32'd0);
    chk("rst_valid", {31'd0, ir_valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_pc", {24'd0, pc_o}, 32'd0);
    launch(2'd0, 8'h00);
    fetch(1);
    chk("first_ir", {24'd0, ir_o}, 32'h0C);
    fetch(15);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      branch_i = (i == 2);
      branch_target_i = 8'h50;
      tick();
      chk("stall_pc", {24'd0, pc_o}, 32'h10);
      chk("stall_ir_pc", {24'd0, ir_pc_o}, 32'h0F);
      chk("stall_ir", {24'd0, ir_o}, {24'd0, rom[8'h0F]});
      chk("stall_valid", {31'd0, ir_valid_o}, 32'd1);
    end
    stall_i = 1'b0;
    branch_i = 1'b0;
    fetch(1);
    chk("cnt_after_stall", {16'd0, fetch_cnt_o}, CNT_ON ? 32'd17 : 32'd0);
    fetch(8'h3C - 8'h11);
    halt_step(61);
    launch(2'd0, 8'h00);
    fetch(8'h31);
    branch_i = 1'b1;
    branch_target_i = 8'h28;
    tick();
    branch_i = 1'b0;
    m_pc = 8'h28;
    chk("br_pc", {24'd0, pc_o}, 32'h28);
    chk("br_bubble", {31'd0, ir_valid_o}, 32'd0);
    chk("br_cnt", {16'd0, fetch_cnt_o}, CNT_ON ? 32'd49 : 32'd0);
    fetch(1);
    chk("br_ir", {24'd0, ir_o}, 32'hFE);
    fetch(8'h3C - 8'h29);
    halt_step(70);
    launch(2'd2, 8'h6D);
    fetch(1);
    branch_i = 1'b1;
    branch_target_i = 8'hFE;
    tick();
    branch_i = 1'b0;
    m_pc = 8'hFE;
    fetch(1);
    chk("wrap_pre", {31'd0, wrap_o}, 32'd0);
    fetch(1);
    chk("wrap_pc", {24'd0, pc_o}, 32'h00);
    chk("wrap_set", {31'd0, wrap_o}, 32'd1);
    start_i = 1'b1;
    prog_sel_i = 2'd1;
    fetch(3);
    start_i = 1'b0;
    chk("wrap_sticky", {31'd0, wrap_o}, 32'd1);
    fetch(8'h3C - 8'h03);
    chk("wrap_sticky2", {31'd0, wrap_o}, 32'd1);
    halt_step(0 + 1 + 2 + 3 + 8'h39 + 1);
    launch(2'd1, 8'h3D);
    fetch(8);
    chk("pre_rst_pc", {24'd0, pc_o}, 32'h45);
    #2 reset = 1'b1;
    #1;
    chk("arst_pc", {24'd0, pc_o}, 32'd0);
    chk("arst_ir", {24'd0, ir_o}, 32'd0);
    chk("arst_ir_pc", {24'd0, ir_pc_o}, 32'd0);
    chk("arst_valid", {31'd0, ir_valid_o}, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_cnt", {16'd0, fetch_cnt_o}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_after_rst", {31'd0, busy_o}, 32'd0);
    launch(2'd1, 8'h3D);
    fetch(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    launch(2'd3, 8'h00);
    fetch(1);
    chk("sel3_ir", {24'd0, ir_o}, 32'h0C);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
